// File: rtl/kbd_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : kbd_cmd_sequencer
// Purpose  : Host-side PS/2 keyboard LED command sequencer (0xED + mask) with
//            open-drain bus arbitration, ACK/response handling, retry, timeout.
// Revision : 1.0 - initial release
// ============================================================================
module kbd_cmd_sequencer #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [2:0] led_mask,
    input  logic       led_req,
    output logic       busy,
    output logic       rx_inhibit,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int c_cnt_max = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam int c_retry_w = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    localparam logic [c_cnt_w-1:0]   c_inh_last = c_cnt_w'(INHIBIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0]   c_inh_end  = c_cnt_w'(INHIBIT_CYCLES);
    localparam logic [c_cnt_w-1:0]   c_to_last  = c_cnt_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_retry_w-1:0] c_max_ret  = c_retry_w'(MAX_RETRIES);

    localparam logic [7:0] c_cmd_leds = 8'hED;
    localparam logic [7:0] c_rsp_ack  = 8'hFA;
    localparam logic [7:0] c_rsp_rsnd = 8'hFE;

    localparam logic [1:0] c_err_timeout = 2'd1;
    localparam logic [1:0] c_err_retries = 2'd2;
    localparam logic [1:0] c_err_frame   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INHIBIT = 3'd1,
        S_TX      = 3'd2,
        S_RX      = 3'd3,
        S_DONE    = 3'd4,
        S_FAIL    = 3'd5
    } state_t;

    state_t                r_state;
    logic                  r_clk_s1, r_clk_s2, r_clk_s3;
    logic                  r_dat_s1, r_dat_s2;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [3:0]            r_bit;
    logic [2:0]            r_mask;
    logic                  r_byte_sel;
    logic [c_retry_w-1:0]  r_retries;
    logic [9:0]            r_rx;

    logic                  w_fall;
    logic [7:0]            w_tx_byte;
    logic                  w_tx_par;
    logic [10:0]           w_frame;
    logic                  w_frame_ok;
    logic [7:0]            w_rx_byte;

    assign w_fall     = r_clk_s3 & ~r_clk_s2;
    assign w_tx_byte  = r_byte_sel ? {5'b0, r_mask} : c_cmd_leds;
    assign w_tx_par   = ~^w_tx_byte;
    // Frame as it stands after the 11th bit: [0] start, [8:1] data, [9] parity, [10] stop
    assign w_frame    = {r_dat_s2, r_rx};
    assign w_frame_ok = ~w_frame[0] & w_frame[10] & (^w_frame[9:1]);
    assign w_rx_byte  = w_frame[8:1];
    assign rx_inhibit = busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_clk_s1    <= 1'b1;
            r_clk_s2    <= 1'b1;
            r_clk_s3    <= 1'b1;
            r_dat_s1    <= 1'b1;
            r_dat_s2    <= 1'b1;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_mask      <= '0;
            r_byte_sel  <= 1'b0;
            r_retries   <= '0;
            r_rx        <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            err_code    <= 2'd0;
        end else begin
            r_clk_s1 <= ps2_clk_in;
            r_clk_s2 <= r_clk_s1;
            r_clk_s3 <= r_clk_s2;
            r_dat_s1 <= ps2_data_in;
            r_dat_s2 <= r_dat_s1;

            case (r_state)
                S_IDLE: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    err         <= 1'b0;
                    if (led_req) begin
                        r_mask     <= led_mask;
                        r_byte_sel <= 1'b0;
                        r_retries  <= '0;
                        err_code   <= 2'd0;
                        r_cnt      <= '0;
                        r_bit      <= '0;
                        ps2_clk_oe <= 1'b1;
                        busy       <= 1'b1;
                        r_state    <= S_INHIBIT;
                    end
                end

                // Clock held low; start bit is asserted while the clock is still held
                S_INHIBIT: begin
                    if (r_cnt == c_inh_end) begin
                        ps2_clk_oe <= 1'b0;
                        r_cnt      <= '0;
                        r_bit      <= '0;
                        r_state    <= S_TX;
                    end else begin
                        if (r_cnt == c_inh_last) begin
                            ps2_data_oe <= 1'b1;
                        end
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_TX: begin
                    if (w_fall) begin
                        r_cnt <= '0;
                        r_bit <= r_bit + 4'd1;
                        if (r_bit < 4'd8) begin
                            ps2_data_oe <= ~w_tx_byte[r_bit[2:0]];
                        end else if (r_bit == 4'd8) begin
                            ps2_data_oe <= ~w_tx_par;
                        end else if (r_bit == 4'd9) begin
                            ps2_data_oe <= 1'b0;
                        end else begin
                            r_bit       <= '0;
                            ps2_data_oe <= 1'b0;
                            if (!r_dat_s2) begin
                                r_state <= S_RX;
                            end else begin
                                err_code <= c_err_frame;
                                err      <= 1'b1;
                                r_state  <= S_FAIL;
                            end
                        end
                    end else if (r_cnt == c_to_last) begin
                        r_cnt       <= '0;
                        err_code    <= c_err_timeout;
                        err         <= 1'b1;
                        ps2_data_oe <= 1'b0;
                        r_state     <= S_FAIL;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_RX: begin
                    ps2_data_oe <= 1'b0;
                    if (w_fall) begin
                        r_cnt <= '0;
                        r_rx  <= {r_dat_s2, r_rx[9:1]};
                        r_bit <= r_bit + 4'd1;
                        if (r_bit == 4'd10) begin
                            r_bit <= '0;
                            if (!w_frame_ok) begin
                                err_code <= c_err_frame;
                                err      <= 1'b1;
                                r_state  <= S_FAIL;
                            end else if (w_rx_byte == c_rsp_ack) begin
                                if (r_byte_sel) begin
                                    done    <= 1'b1;
                                    r_state <= S_DONE;
                                end else begin
                                    r_byte_sel <= 1'b1;
                                    r_retries  <= '0;
                                    ps2_clk_oe <= 1'b1;
                                    r_state    <= S_INHIBIT;
                                end
                            end else if (w_rx_byte == c_rsp_rsnd) begin
                                if (r_retries < c_max_ret) begin
                                    r_retries  <= r_retries + 1'b1;
                                    ps2_clk_oe <= 1'b1;
                                    r_state    <= S_INHIBIT;
                                end else begin
                                    err_code <= c_err_retries;
                                    err      <= 1'b1;
                                    r_state  <= S_FAIL;
                                end
                            end else begin
                                err_code <= c_err_frame;
                                err      <= 1'b1;
                                r_state  <= S_FAIL;
                            end
                        end
                    end else if (r_cnt == c_to_last) begin
                        r_cnt    <= '0;
                        err_code <= c_err_timeout;
                        err      <= 1'b1;
                        r_state  <= S_FAIL;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                S_FAIL: begin
                    err         <= 1'b0;
                    busy        <= 1'b0;
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    r_state     <= S_IDLE;
                end

                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    busy        <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
